fht_engine: RTL and testbench
=============================

FHT_ENGINE -- requirements
Module: fht_engine

Interface
REQ-001 SHALL have parameter W, default 8: signed input sample width, range 2..16.
REQ-002 SHALL have parameter LOG2N, default 3: log2 of transform size N = 2^LOG2N, range 1..6.
REQ-003 SHALL use derived width OW = W + LOG2N for every signed output sample.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data and in_inv are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a vector.
REQ-008 SHALL have port in_data, input, N*W bits: sample k occupies bits [k*W +: W], two's complement.
REQ-009 SHALL have port in_inv, input, 1 bit: 1 selects inverse mode, i.e. result arithmetic-shifted right by LOG2N.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a completed transform.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 SHALL have port out_data, output, N*OW bits: coefficient k occupies bits [k*OW +: OW], natural (Sylvester) order.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL set in_ready high only in IDLE; out_valid high only in DONE.
REQ-016 SHALL, on in_valid and in_ready at an edge, sign-extend each sample to OW into the working register, latch in_inv, clear the stage counter, and enter RUN.
REQ-017 SHALL, on each RUN edge, replace the working vector v with v' such that, for k < N/2, v'[k] = v[2k] + v[2k+1] and v'[k+N/2] = v[2k] - v[2k+1] (constant-geometry butterfly).
REQ-018 SHALL increment the stage counter on each RUN edge and enter DONE on the edge that completes stage LOG2N-1.
REQ-019 SHALL therefore assert out_valid exactly LOG2N+1 edges after the accepting edge.
REQ-020 SHALL perform all arithmetic at OW bits; no overflow is possible for any input, and no saturation is present.
REQ-021 SHALL, when the latched in_inv = 1, present each coefficient arithmetic-shifted right by LOG2N (floor rounding), sign-extended to OW.
REQ-022 SHALL hold out_data and out_valid stable in DONE while out_ready is low.
REQ-023 SHALL return to IDLE on the edge where out_valid and out_ready are both high; out_data keeps its last value.
REQ-024 SHALL ignore in_valid, in_data and in_inv outside IDLE, including changes to in_inv while in RUN.
REQ-025 SHALL handle LOG2N = 1 so that RUN lasts exactly one cycle.

Reset
REQ-026 SHALL, while reset is low, force: state IDLE, in_ready 1, out_valid 0, busy 0, out_data 0, working register 0, stage counter 0, latched mode 0.
REQ-027 SHALL abort any transform in progress on reset assertion in RUN or DONE; no partial result is ever flagged valid.
REQ-028 SHALL accept a new vector on the first edge after reset deassertion if in_valid is high.

Structure
REQ-029 SHALL place the FSM state enum and an OW width function in shared package fht_pkg.
REQ-030 SHALL implement one combinational sub-module, fht_cg_stage, parametrised by OW and LOG2N, computing REQ-017; it SHALL be instantiated once and reused every RUN cycle.

Verification (N=8, W=8, OW=11 unless noted)
REQ-031 SHALL cover impulse: x = [1,0,0,0,0,0,0,0], in_inv = 0 -> all y = 1; out_valid rises on the 4th edge after acceptance.
REQ-032 SHALL cover the Walsh row: x = [1,-1,1,-1,1,-1,1,-1] -> y[1] = 8, all other y = 0; all x = -128 -> y[0] = -1024, all other y = 0.
REQ-033 SHALL cover inverse mode: all x = 1 with in_inv = 1 -> y[0] = 1, all other y = 0; all x = -1 with in_inv = 1 -> y[0] = -1 (floor).
REQ-034 SHALL cover backpressure: hold out_ready low for 5 cycles in DONE -> out_data stable, in_ready = 0, and in_valid pulses ignored; raise out_ready -> IDLE on the next edge.
REQ-035 SHALL cover reset mid-operation: assert reset at RUN stage 1 -> all outputs at reset values immediately; the next vector gives a correct result.
REQ-036 SHALL cover the small configuration LOG2N = 1, W = 4: x = [7,-8] -> y = [-1, 15] at OW = 5, out_valid on the 2nd edge after acceptance.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared definitions for the fast Hadamard transform engine: FSM encoding and
// the output-width rule used by the top and by the bench.
package fht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fht_state_t;

  // Wide enough to count stages 0..LOG2N-1 for LOG2N up to 6
  localparam int CNT_W = 3;

  function automatic int fht_ow(input int w, input int log2n);
    return w + log2n;
  endfunction

endpackage

// File: rtl/fht_cg_stage.sv
// One constant-geometry radix-2 Hadamard stage: pairs (2k, 2k+1) feed sum to
// slot k and difference to slot k+N/2, so the same wiring serves every stage.
module fht_cg_stage #(
  parameter int OW    = 11,
  parameter int LOG2N = 3
) (
  input  logic [(1<<LOG2N)*OW-1:0] vec_in,
  output logic [(1<<LOG2N)*OW-1:0] vec_out
);

  localparam int N = 1 << LOG2N;
  localparam int H = N / 2;

  for (genvar k = 0; k < H; k++) begin : g_bfly
    logic signed [OW-1:0] a;
    logic signed [OW-1:0] b;
    assign a = vec_in[(2*k)*OW +: OW];
    assign b = vec_in[(2*k+1)*OW +: OW];
    assign vec_out[k*OW +: OW]     = a + b;
    assign vec_out[(k+H)*OW +: OW] = a - b;
  end

endmodule

// File: rtl/fht_engine.sv
// Iterative N-point fast Hadamard transform: one shared butterfly stage applied
// LOG2N times to a working register, with optional 1/N scaling for the inverse.
module fht_engine
  import fht_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2N = 3,
  localparam int N    = 1 << LOG2N,
  localparam int OW   = fht_ow(W, LOG2N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            in_inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*OW-1:0] out_data,
  output logic            busy
);

  fht_state_t        state;
  fht_state_t        state_nxt;
  logic [CNT_W-1:0]  stage_cnt;
  logic              inv_q;
  logic [N*OW-1:0]   vec_q;
  logic [N*OW-1:0]   vec_bfly;
  logic              accept;
  logic              last_stage;

  function automatic logic signed [OW-1:0] inv_scale(input logic signed [OW-1:0] c);
    return c >>> LOG2N;
  endfunction

  assign accept     = in_valid && in_ready;
  assign last_stage = (stage_cnt == CNT_W'(LOG2N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)   state_nxt = ST_RUN;
      ST_RUN:  if (last_stage) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  fht_cg_stage #(
    .OW    (OW),
    .LOG2N (LOG2N)
  ) u_stage (
    .vec_in  (vec_q),
    .vec_out (vec_bfly)
  );

  // Working register is also the result register; it only moves in IDLE/RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_q     <= '0;
      stage_cnt <= '0;
      inv_q     <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < N; k++)
        vec_q[k*OW +: OW] <= OW'($signed(in_data[k*W +: W]));
      stage_cnt <= '0;
      inv_q     <= in_inv;
    end else if (state == ST_RUN) begin
      vec_q     <= vec_bfly;
      stage_cnt <= stage_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign out_data[k*OW +: OW] = inv_q ? inv_scale(vec_q[k*OW +: OW]) : vec_q[k*OW +: OW];
  end

endmodule

// File: tb/tb_fht_engine.sv
// Directed bench for fht_engine: an N=8/W=8 instance for the main cases and an
// N=2/W=4 instance for the smallest configuration.
module tb_fht_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_inv, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [87:0] out_data;

  logic        b_in_valid, b_in_inv, b_out_ready;
  logic [7:0]  b_in_data;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [9:0]  b_out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fht_engine #(.W(8), .LOG2N(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  fht_engine #(.W(4), .LOG2N(1)) dut_small (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_in(input int x[8]);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(x[k]);
    return r;
  endfunction

  function automatic logic [87:0] pack_out(input int y[8]);
    logic [87:0] r;
    for (int k = 0; k < 8; k++) r[k*11 +: 11] = 11'(y[k]);
    return r;
  endfunction

  // Call with inputs already driven; consumes the accepting edge and the RUN edges
  task automatic finish_vec(input string tag, input logic [87:0] exp, input logic inv);
    @(posedge clk); #1;
    check($sformatf("%s accept", tag), busy, 1'b1);
    in_valid = 1'b0;
    in_inv   = ~inv;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s early", tag), out_valid, 1'b0);
    @(posedge clk); #1;
    check($sformatf("%s valid", tag), out_valid, 1'b1);
    check($sformatf("%s data", tag), out_data, exp);
  endtask

  task automatic release_out(input string tag, input logic [87:0] exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check($sformatf("%s idle", tag), in_ready, 1'b1);
    check($sformatf("%s vld_low", tag), out_valid, 1'b0);
    check($sformatf("%s hold", tag), out_data, exp);
    out_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input int x[8], input logic inv, input int y[8]);
    @(negedge clk);
    in_data  = pack_in(x);
    in_inv   = inv;
    in_valid = 1'b1;
    finish_vec(tag, pack_out(y), inv);
    release_out(tag, pack_out(y));
  endtask

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int x[8];
    int y[8];
    reset = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
    b_in_valid = 1'b0; b_in_inv = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    #3 reset = 1'b0;
    #1;
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst out_data", out_data, 88'd0);
    check("rst small out_data", b_out_data, 10'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    x = '{1, 0, 0, 0, 0, 0, 0, 0};       y = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_case("impulse", x, 1'b0, y);
    x = '{1, -1, 1, -1, 1, -1, 1, -1};   y = '{0, 8, 0, 0, 0, 0, 0, 0};
    run_case("walsh", x, 1'b0, y);
    x = '{-128, -128, -128, -128, -128, -128, -128, -128};
    y = '{-1024, 0, 0, 0, 0, 0, 0, 0};
    run_case("neg_full", x, 1'b0, y);
    x = '{127, 127, 127, 127, 127, 127, 127, 127};
    y = '{1016, 0, 0, 0, 0, 0, 0, 0};
    run_case("pos_full", x, 1'b0, y);
    x = '{1, 2, 3, 4, 5, 6, 7, 8};       y = '{36, -4, -8, 0, -16, 0, 0, 0};
    run_case("ramp", x, 1'b0, y);
    x = '{1, 1, 1, 1, 1, 1, 1, 1};       y = '{1, 0, 0, 0, 0, 0, 0, 0};
    run_case("inv_ones", x, 1'b1, y);
    x = '{-1, -1, -1, -1, -1, -1, -1, -1}; y = '{-1, 0, 0, 0, 0, 0, 0, 0};
    run_case("inv_neg", x, 1'b1, y);
    x = '{1, 2, 3, 4, 5, 6, 7, 8};       y = '{4, -1, -1, 0, -2, 0, 0, 0};
    run_case("inv_ramp", x, 1'b1, y);

    // Backpressure: result must sit still while in_valid pulses are ignored
    x = '{1, 0, 0, 0, 0, 0, 0, 0};       y = '{1, 1, 1, 1, 1, 1, 1, 1};
    @(negedge clk);
    in_data = pack_in(x); in_inv = 1'b0; in_valid = 1'b1;
    finish_vec("bp", pack_out(y), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 64'h0102_0304_0506_0708 + 64'(i);
      @(posedge clk); #1;
      check($sformatf("bp valid %0d", i), out_valid, 1'b1);
      check($sformatf("bp in_ready %0d", i), in_ready, 1'b0);
      check($sformatf("bp data %0d", i), out_data, pack_out(y));
    end
    in_valid = 1'b0;
    release_out("bp", pack_out(y));

    // Reset while the second stage is pending, then accept on the first edge after release
    x = '{1, 2, 3, 4, 5, 6, 7, 8};
    @(negedge clk);
    in_data = pack_in(x); in_inv = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid in_ready", in_ready, 1'b1);
    check("mid out_valid", out_valid, 1'b0);
    check("mid busy_low", busy, 1'b0);
    check("mid out_data", out_data, 88'd0);
    x = '{1, -1, 1, -1, 1, -1, 1, -1};   y = '{0, 8, 0, 0, 0, 0, 0, 0};
    in_data = pack_in(x); in_inv = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    finish_vec("post_rst", pack_out(y), 1'b0);
    release_out("post_rst", pack_out(y));

    // Smallest configuration: x = [7, -8] -> y = [-1, 15] at 5 bits
    @(negedge clk);
    b_in_data = {4'b1000, 4'b0111}; b_in_inv = 1'b0; b_in_valid = 1'b1;
    @(posedge clk); #1;
    check("small accept", b_busy, 1'b1);
    check("small early", b_out_valid, 1'b0);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("small valid", b_out_valid, 1'b1);
    check("small data", b_out_data, {5'd15, 5'b11111});
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    check("small idle", b_in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
